// File: rtl/sync_edge_pkg.sv
// rtl/sync_edge_pkg.sv - shared types and sizing helper for the sync_edge_filter block
package sync_edge_pkg;

    // Per-channel edge selection, two bits per channel on edge_mode.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Filter counter width: $clog2(filt_cycles), never narrower than one bit.
    function automatic int cnt_width(input int filt_cycles);
        return (filt_cycles > 1) ? $clog2(filt_cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_edge_ch.sv
// rtl/sync_edge_ch.sv - one channel: synchroniser, glitch filter and edge pulses
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   sig_in       asynchronous raw input
//   edge_mode    edge selection for edge_pulse (edge_mode_e encoding)
//   level        filtered, synchronised level
//   rise_pulse   one-cycle pulse on an accepted 0->1
//   fall_pulse   one-cycle pulse on an accepted 1->0
//   edge_pulse   one-cycle pulse on an accepted edge selected by edge_mode
module sync_edge_ch
    import sync_edge_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_in,
    input  logic [1:0] edge_mode,
    output logic       level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       edge_pulse
);

    localparam int            CW       = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CW-1:0]          cnt_q;
    logic                   accept;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   edge_nxt;
    edge_mode_e             mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // A new level is accepted on the edge where it has already been seen
    // FILT_CYCLES-1 times in a row and is seen once more.
    assign accept   = (sync_out != level) && (cnt_q == CNT_LAST);
    assign mode     = edge_mode_e'(edge_mode);
    assign rise_nxt = accept & sync_out;
    assign fall_nxt = accept & ~sync_out;
    assign edge_nxt = (rise_nxt & ((mode == EDGE_RISE) || (mode == EDGE_BOTH))) |
                      (fall_nxt & ((mode == EDGE_FALL) || (mode == EDGE_BOTH)));

    // Any return to the current level throws away a partial count, so a
    // glitch shorter than FILT_CYCLES never moves the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= RESET_LEVEL;
            cnt_q <= '0;
        end else if (sync_out == level) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            level <= sync_out;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Loaded every cycle, so each pulse lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            edge_pulse <= edge_nxt;
        end
    end

endmodule

// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - multi-channel synchronising glitch filter with edge pulses
//
// Optional sticky flags are built when SYNC_EDGE_STICKY_EN is defined; otherwise
// edge_flag is tied to 0 and flag_clr is ignored.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   sig_in       [CH]   asynchronous raw inputs
//   edge_mode    [2*CH] per-channel mode, bits [2i+1:2i]
//   level_out    [CH]   filtered, synchronised levels
//   rise_pulse   [CH]   one-cycle pulse on accepted 0->1
//   fall_pulse   [CH]   one-cycle pulse on accepted 1->0
//   edge_pulse   [CH]   one-cycle pulse on accepted edge matching edge_mode
//   flag_clr     [CH]   sticky flag clear
//   edge_flag    [CH]   sticky edge flag
module sync_edge_filter
    import sync_edge_pkg::*;
#(
    parameter int   CH          = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   sig_in,
    input  logic [2*CH-1:0] edge_mode,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   rise_pulse,
    output logic [CH-1:0]   fall_pulse,
    output logic [CH-1:0]   edge_pulse,
    input  logic [CH-1:0]   flag_clr,
    output logic [CH-1:0]   edge_flag
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        sync_edge_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sig_in     (sig_in[i]),
            .edge_mode  (edge_mode[2*i +: 2]),
            .level      (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i]),
            .edge_pulse (edge_pulse[i])
        );
    end

`ifdef SYNC_EDGE_STICKY_EN
    // Set has priority over clear so an edge arriving with a clear is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_flag <= '0;
        end else begin
            edge_flag <= edge_pulse | (edge_flag & ~flag_clr);
        end
    end
`else
    logic unused_flag_clr;
    assign unused_flag_clr = ^flag_clr;
    assign edge_flag       = '0;
`endif

endmodule
